// File: rtl/freq_gate_sequencer_pkg.sv
// Shared types and defaults for the frequency-meter gate sequencer.
// Contents: the FSM state enum, default parameter values and the gate-length helper.
package freq_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_GATE  = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  localparam int unsigned DEF_GATE_W    = 24;
  localparam int unsigned DEF_GATE_BASE = 10;
  localparam int unsigned DEF_MODE_W    = 2;
  localparam int unsigned DEF_TEST_GATE = 4;
  localparam int unsigned DEF_CLEAR_LEN = 2;
  localparam int unsigned DEF_LATCH_LEN = 2;

  // Gate length in clock cycles for a given range: base << range.
  function automatic logic [63:0] gate_len(input logic [63:0] base, input int unsigned range);
    return base << range;
  endfunction

endpackage

// File: rtl/freq_gate_sequencer_gate_timer.sv
// gate_timer: loadable GATE_W-bit down-counter that saturates at zero.
// expired is high while the count is zero. count_next exposes the value the
// counter takes at the next edge so the owner can register strobes that
// coincide with the final cycle of a phase.
module gate_timer
  import freq_ctl_pkg::*;
#(
  parameter int unsigned GATE_W = DEF_GATE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [GATE_W-1:0] load_val,
  input  logic              en,
  output logic              expired,
  output logic [GATE_W-1:0] count_next
);

  logic [GATE_W-1:0] count_q;
  logic [GATE_W-1:0] count_d;

  // Next count: load wins, otherwise decrement toward zero and hold there.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - GATE_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired    = (count_q == '0);
  assign count_next = count_d;

endmodule

// File: rtl/freq_gate_sequencer.sv
// freq_gate_sequencer: generates the repeating clear -> gate -> latch frame for
// the frequency counter datapath, with run/stop control and a frame-done strobe.
// Optional feature macro: AUTORANGE_EN (overflow-driven range step-down).
module freq_gate_sequencer
  import freq_ctl_pkg::*;
#(
  parameter int unsigned GATE_W    = DEF_GATE_W,
  parameter int unsigned GATE_BASE = DEF_GATE_BASE,
  parameter int unsigned MODE_W    = DEF_MODE_W,
  parameter int unsigned TEST_GATE = DEF_TEST_GATE,
  parameter int unsigned CLEAR_LEN = DEF_CLEAR_LEN,
  parameter int unsigned LATCH_LEN = DEF_LATCH_LEN
) (
  input  logic              clkControl,
  input  logic              reset,
  input  logic              runEn,
  input  logic              testMode,
  input  logic [MODE_W-1:0] modeControl,
  input  logic              ovf,
  output logic              enable,
  output logic              clear,
  output logic              latch,
  output logic [MODE_W-1:0] rangeOut,
  output logic              frameDone
);

  localparam logic [63:0] MAX_GATE  = gate_len(64'(GATE_BASE), (32'd1 << MODE_W) - 32'd1);
  localparam logic [63:0] TIMER_MAX = (GATE_W >= 64) ? '1 : ((64'd1 << GATE_W) - 64'd1);

  if (MAX_GATE > TIMER_MAX) begin : g_gate_w_check
    $error("GATE_W too narrow for GATE_BASE << (2**MODE_W-1)");
  end
  if (64'(TEST_GATE) > TIMER_MAX || TEST_GATE < 1) begin : g_test_gate_check
    $error("TEST_GATE must be >= 1 and fit in GATE_W bits");
  end
  if (CLEAR_LEN < 1 || LATCH_LEN < 1) begin : g_pulse_len_check
    $error("CLEAR_LEN and LATCH_LEN must be >= 1");
  end

  localparam logic [GATE_W-1:0] CLEAR_LOAD = GATE_W'(CLEAR_LEN - 1);
  localparam logic [GATE_W-1:0] LATCH_LOAD = GATE_W'(LATCH_LEN - 1);
  localparam logic [GATE_W-1:0] TEST_LOAD  = GATE_W'(TEST_GATE - 1);

  state_e            state_q, state_d;
  logic              enable_q, enable_d;
  logic              clear_q, clear_d;
  logic              latch_q, latch_d;
  logic              frame_done_q, frame_done_d;
  logic [MODE_W-1:0] range_out_q, range_out_d;
  logic [MODE_W-1:0] range_sel;

  logic              timer_load;
  logic [GATE_W-1:0] timer_val;
  logic              timer_en;
  logic              timer_expired;
  logic [GATE_W-1:0] timer_next;
  logic [GATE_W-1:0] gate_load;

`ifdef AUTORANGE_EN
  logic [MODE_W-1:0] range_q, range_d;
  assign range_sel = range_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
  assign range_sel  = modeControl;
`endif

  assign gate_load = testMode ? TEST_LOAD
                              : GATE_W'(gate_len(64'(GATE_BASE), 32'(range_sel)) - 64'd1);
  assign timer_en  = (state_q != ST_IDLE);

  gate_timer #(
    .GATE_W(GATE_W)
  ) u_gate_timer (
    .clk       (clkControl),
    .reset     (reset),
    .load      (timer_load),
    .load_val  (timer_val),
    .en        (timer_en),
    .expired   (timer_expired),
    .count_next(timer_next)
  );

  // Next state, timer loads, range bookkeeping and registered-output decode.
  always_comb begin
    state_d     = state_q;
    timer_load  = 1'b0;
    timer_val   = '0;
    range_out_d = range_out_q;
`ifdef AUTORANGE_EN
    range_d     = range_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (runEn) begin
          state_d    = ST_CLEAR;
          timer_load = 1'b1;
          timer_val  = CLEAR_LOAD;
`ifdef AUTORANGE_EN
          range_d    = modeControl;
`endif
        end
      end
      ST_CLEAR: begin
        if (timer_expired) begin
          state_d     = ST_GATE;
          timer_load  = 1'b1;
          timer_val   = gate_load;
          range_out_d = range_sel;
        end
      end
      ST_GATE: begin
        if (timer_expired) begin
          state_d    = ST_LATCH;
          timer_load = 1'b1;
          timer_val  = LATCH_LOAD;
`ifdef AUTORANGE_EN
          if (ovf && (range_q != '0)) begin
            range_d = range_q - MODE_W'(1);
          end
`endif
        end
      end
      ST_LATCH: begin
        if (timer_expired) begin
          if (runEn) begin
            state_d    = ST_CLEAR;
            timer_load = 1'b1;
            timer_val  = CLEAR_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are a registered decode of the next state; frameDone marks the
    // latch cycle whose timer value will be zero, i.e. the last one.
    enable_d     = (state_d == ST_GATE);
    clear_d      = (state_d == ST_CLEAR);
    latch_d      = (state_d == ST_LATCH);
    frame_done_d = (state_d == ST_LATCH) && (timer_next == '0);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clkControl) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      enable_q     <= 1'b0;
      clear_q      <= 1'b0;
      latch_q      <= 1'b0;
      frame_done_q <= 1'b0;
      range_out_q  <= '0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      clear_q      <= clear_d;
      latch_q      <= latch_d;
      frame_done_q <= frame_done_d;
      range_out_q  <= range_out_d;
    end
  end

`ifdef AUTORANGE_EN
  // Working range register for auto-ranging.
  always_ff @(posedge clkControl) begin
    if (reset) begin
      range_q <= '0;
    end else begin
      range_q <= range_d;
    end
  end
`endif

  assign enable    = enable_q;
  assign clear     = clear_q;
  assign latch     = latch_q;
  assign frameDone = frame_done_q;
  assign rangeOut  = range_out_q;

endmodule

// File: tb/tb_freq_gate_sequencer.sv
// Directed self-checking bench for freq_gate_sequencer at default parameters.
module tb_freq_gate_sequencer;

  logic       clkControl = 1'b0;
  logic       reset;
  logic       runEn;
  logic       testMode;
  logic [1:0] modeControl;
  logic       ovf;
  logic       enable;
  logic       clear;
  logic       latch;
  logic [1:0] rangeOut;
  logic       frameDone;

  int total = 0;
  int bad   = 0;

  always #5 clkControl = ~clkControl;

  freq_gate_sequencer #(
    .GATE_W   (24),
    .GATE_BASE(10),
    .MODE_W   (2),
    .TEST_GATE(4),
    .CLEAR_LEN(2),
    .LATCH_LEN(2)
  ) dut (
    .clkControl (clkControl),
    .reset      (reset),
    .runEn      (runEn),
    .testMode   (testMode),
    .modeControl(modeControl),
    .ovf        (ovf),
    .enable     (enable),
    .clear      (clear),
    .latch      (latch),
    .rangeOut   (rangeOut),
    .frameDone  (frameDone)
  );

  task automatic step();
    @(negedge clkControl);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Measure one frame starting at (or waiting for) clear. At gate cycle chg_at
  // the inputs modeControl/runEn are driven to chg_mode/chg_run.
  task automatic run_frame(input int chg_at, input logic [1:0] chg_mode, input logic chg_run,
                           output int c, output int g, output int l, output int fd,
                           output int bad_fd, output int excl);
    int guard;
    c = 0; g = 0; l = 0; fd = 0; bad_fd = 0; excl = 0; guard = 0;
    while (clear !== 1'b1 && guard < 300) begin
      step();
      guard++;
    end
    while (clear === 1'b1 && c < 300) begin
      if ($countones({enable, clear, latch}) > 1 || frameDone) excl++;
      c++;
      step();
    end
    while (enable === 1'b1 && g < 300) begin
      if (g == chg_at) begin
        modeControl = chg_mode;
        runEn       = chg_run;
      end
      if ($countones({enable, clear, latch}) > 1 || frameDone) excl++;
      g++;
      step();
    end
    while (latch === 1'b1 && l < 300) begin
      if ($countones({enable, clear, latch}) > 1) excl++;
      if (frameDone === 1'b1) begin
        fd++;
        if (l != 1) bad_fd++;
      end
      l++;
      step();
    end
  endtask

  int c, g, l, fd, bfd, ex, idle_hi, guard;
`ifdef AUTORANGE_EN
  localparam int B_GATE = 20, B_RANGE = 1, C_GATE = 10, C_RANGE = 0;
`else
  localparam int B_GATE = 40, B_RANGE = 2, C_GATE = 80, C_RANGE = 3;
`endif

  initial begin
    reset = 1'b1; runEn = 1'b0; testMode = 1'b0; ovf = 1'b0; modeControl = 2'd0;
    step(); step();
    chkb("rst_enable", enable, 1'b0);
    chkb("rst_clear", clear, 1'b0);
    chkb("rst_latch", latch, 1'b0);
    chkb("rst_frameDone", frameDone, 1'b0);
    chk("rst_rangeOut", 32'(rangeOut), 0);

    // 1: basic frame, range 0
    reset = 1'b0; runEn = 1'b1;
    step();
    chkb("t1_first_clear", clear, 1'b1);
    run_frame(-1, 2'd0, 1'b1, c, g, l, fd, bfd, ex);
    chk("t1_clear_len", c, 2);
    chk("t1_gate_len", g, 10);
    chk("t1_latch_len", l, 2);
    chk("t1_frameDone_cnt", fd, 1);
    chk("t1_frameDone_pos", bfd, 0);
    chk("t1_exclusive", ex, 0);
    chk("t1_period", c + g + l, 14);
    chkb("t1_back_to_back", clear, 1'b1);
    chk("t1_rangeOut", 32'(rangeOut), 0);

    // 2: range 3, mode change mid-gate ignored
    modeControl = 2'd3;
    run_frame(40, 2'd0, 1'b1, c, g, l, fd, bfd, ex);
    chk("t2_gate_len", g, 80);
    chk("t2_rangeOut", 32'(rangeOut), 3);
    chk("t2_exclusive", ex, 0);
    chkb("t2_back_to_back", clear, 1'b1);
    run_frame(-1, 2'd0, 1'b1, c, g, l, fd, bfd, ex);
    chk("t2_next_gate_len", g, 10);
    chk("t2_next_rangeOut", 32'(rangeOut), 0);

    // 3: test gate, two 8-cycle frames
    testMode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run_frame(-1, 2'd0, 1'b1, c, g, l, fd, bfd, ex);
      chk("t3_gate_len", g, 4);
      chk("t3_frameDone_cnt", fd, 1);
      chk("t3_period", c + g + l, 8);
      chkb("t3_back_to_back", clear, 1'b1);
    end

    // 4: stop during gate, frame completes then idle
    testMode = 1'b0; modeControl = 2'd1;
    run_frame(5, 2'd1, 1'b0, c, g, l, fd, bfd, ex);
    chk("t4_gate_len", g, 20);
    chk("t4_latch_len", l, 2);
    chk("t4_frameDone_cnt", fd, 1);
    chk("t4_rangeOut", 32'(rangeOut), 1);
    chkb("t4_idle_clear", clear, 1'b0);
    chkb("t4_idle_enable", enable, 1'b0);
    idle_hi = 0;
    for (int i = 0; i < 5; i++) begin
      if (enable || clear || latch || frameDone) idle_hi++;
      step();
    end
    chk("t4_stays_idle", idle_hi, 0);

    // 5: reset mid-gate
    runEn = 1'b1;
    step();
    chkb("t5_clear", clear, 1'b1);
    guard = 0;
    while (enable !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    chkb("t5_gate_started", enable, 1'b1);
    step(); step(); step();
    reset = 1'b1; runEn = 1'b0;
    step();
    chkb("t5_enable", enable, 1'b0);
    chkb("t5_clear_off", clear, 1'b0);
    chkb("t5_latch", latch, 1'b0);
    chkb("t5_frameDone", frameDone, 1'b0);
    chk("t5_rangeOut", 32'(rangeOut), 0);
    reset = 1'b0;
    idle_hi = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (enable || clear || latch || frameDone) idle_hi++;
    end
    chk("t5_no_latch", idle_hi, 0);

    // 6: overflow at gate end (auto-range steps down when enabled)
    ovf = 1'b1; modeControl = 2'd2; runEn = 1'b1;
    step();
    chkb("t6_clear", clear, 1'b1);
    run_frame(-1, 2'd2, 1'b1, c, g, l, fd, bfd, ex);
    chk("t6a_gate_len", g, 40);
    chk("t6a_rangeOut", 32'(rangeOut), 2);
    run_frame(0, 2'd3, 1'b1, c, g, l, fd, bfd, ex);
    chk("t6b_gate_len", g, B_GATE);
    chk("t6b_rangeOut", 32'(rangeOut), B_RANGE);
    run_frame(-1, 2'd3, 1'b1, c, g, l, fd, bfd, ex);
    chk("t6c_gate_len", g, C_GATE);
    chk("t6c_rangeOut", 32'(rangeOut), C_RANGE);
    run_frame(0, 2'd3, 1'b0, c, g, l, fd, bfd, ex);
    chk("t6d_gate_len", g, C_GATE);
    chk("t6d_rangeOut", 32'(rangeOut), C_RANGE);
    chkb("t6d_idle", clear, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
